// File: rtl/history_stream_arbiter.sv
// Round-robin shared two/three-deep history detector over NUM_CH independent 1-bit streams.
// Define RUN_LEN_EN to add per-channel run-length counters and the run_len output.
module history_stream_arbiter #(
    parameter int NUM_CH = 4,
    parameter int RUN_W  = 8,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] a_in,
    input  logic [NUM_CH-1:0] clr,
    output logic [NUM_CH-1:0] gnt,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_x,
    output logic              out_y
`ifdef RUN_LEN_EN
    ,
    output logic [RUN_W-1:0]  run_len
`endif
);

    typedef enum logic [1:0] {H_EMPTY, H_ONE, H_FULL} h_state_e;

    h_state_e          st_q [NUM_CH];
    h_state_e          st_d [NUM_CH];
    logic [NUM_CH-1:0] h0_q, h0_d, h1_q, h1_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic              accept;
    logic [CH_W-1:0]   gnt_idx;
    h_state_e          cur_st;
    logic              cur_h0, cur_h1, a_sel;

    logic              out_valid_q, out_valid_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic              out_x_q, out_x_d, out_y_q, out_y_d;

`ifdef RUN_LEN_EN
    logic [RUN_W-1:0]  run_q [NUM_CH];
    logic [RUN_W-1:0]  run_d [NUM_CH];
    logic [RUN_W-1:0]  run_len_q, run_len_d, cur_run, new_run;
`endif

    // First asserted request at or after rr_ptr, wrapping; gnt implies req.
    always_comb begin : rr_pick
        int idx;
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        accept  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!accept && req[idx]) begin
                accept       = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = CH_W'(idx);
            end
        end
    end

    // Pre-update context of the granted channel; a same-cycle clr flushes it first.
    always_comb begin
        a_sel = a_in[gnt_idx];
        if (clr[gnt_idx]) begin
            cur_st = H_EMPTY;
            cur_h0 = 1'b0;
            cur_h1 = 1'b0;
        end else begin
            cur_st = st_q[gnt_idx];
            cur_h0 = h0_q[gnt_idx];
            cur_h1 = h1_q[gnt_idx];
        end
`ifdef RUN_LEN_EN
        cur_run = clr[gnt_idx] ? '0 : run_q[gnt_idx];
        if (cur_st == H_EMPTY || a_sel != cur_h0)
            new_run = RUN_W'(1);
        else if (cur_run == {RUN_W{1'b1}})
            new_run = cur_run;
        else
            new_run = cur_run + RUN_W'(1);
`endif
    end

    // Next-state: context FSMs and round-robin pointer.
    always_comb begin
        st_d     = st_q;
        h0_d     = h0_q;
        h1_d     = h1_q;
        rr_ptr_d = rr_ptr_q;
`ifdef RUN_LEN_EN
        run_d    = run_q;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            if (clr[i]) begin
                st_d[i] = H_EMPTY;
                h0_d[i] = 1'b0;
                h1_d[i] = 1'b0;
`ifdef RUN_LEN_EN
                run_d[i] = '0;
`endif
            end
        end
        if (accept) begin
            st_d[gnt_idx] = (cur_st == H_EMPTY) ? H_ONE : H_FULL;
            h1_d[gnt_idx] = cur_h0;
            h0_d[gnt_idx] = a_sel;
`ifdef RUN_LEN_EN
            run_d[gnt_idx] = new_run;
`endif
            rr_ptr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Output: flags forced to 0 when nothing is accepted.
    always_comb begin
        out_valid_d = accept;
        out_ch_d    = accept ? gnt_idx : out_ch_q;
        out_x_d     = accept && (cur_st != H_EMPTY) && (a_sel == cur_h0);
        out_y_d     = accept && (cur_st == H_FULL) && (a_sel == cur_h0) && (a_sel == cur_h1);
`ifdef RUN_LEN_EN
        run_len_d   = accept ? new_run : run_len_q;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the context arrays are reset explicitly because H_EMPTY carries meaning, not just init.
            st_q        <= '{default: H_EMPTY};
            h0_q        <= '0;
            h1_q        <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_x_q     <= 1'b0;
            out_y_q     <= 1'b0;
`ifdef RUN_LEN_EN
            run_q       <= '{default: '0};
            run_len_q   <= '0;
`endif
        end else begin
            st_q        <= st_d;
            h0_q        <= h0_d;
            h1_q        <= h1_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
`ifdef RUN_LEN_EN
            run_q       <= run_d;
            run_len_q   <= run_len_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
`ifdef RUN_LEN_EN
    assign run_len   = run_len_q;
`endif

endmodule

// File: tb/tb_history_stream_arbiter.sv
// Directed, table-driven bench for history_stream_arbiter (NUM_CH = 4).
// With RUN_LEN_EN defined the DUT is built with RUN_W = 2 to exercise saturation.
module tb_history_stream_arbiter;

    localparam int NUM_CH = 4;
`ifdef RUN_LEN_EN
    localparam int RUN_W = 2;
`else
    localparam int RUN_W = 8;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req, a_in, clr;
    logic [3:0]  gnt;
    logic        out_valid, out_x, out_y;
    logic [1:0]  out_ch;
`ifdef RUN_LEN_EN
    logic [RUN_W-1:0] run_len;
`endif

    int checks   = 0;
    int failures = 0;

    history_stream_arbiter #(.NUM_CH(NUM_CH), .RUN_W(RUN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .a_in      (a_in),
        .clr       (clr),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_x     (out_x),
        .out_y     (out_y)
`ifdef RUN_LEN_EN
        ,
        .run_len   (run_len)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst_before;
        logic [3:0] req;
        logic [3:0] a;
        logic [3:0] clr;
        logic [3:0] exp_gnt;
        logic       exp_valid;
        logic [1:0] exp_ch;
        logic       exp_x;
        logic       exp_y;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit rb, logic [3:0] rq, logic [3:0] a, logic [3:0] cl,
                                logic [3:0] g, logic v, logic [1:0] ch, logic x, logic y);
        vecs.push_back('{rb, rq, a, cl, g, v, ch, x, y});
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reset held over two edges; returns at a falling edge with reset released.
    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        a_in  = '0;
        clr   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Inputs driven at a falling edge; gnt checked combinationally, result #1 after the next rising edge.
    task automatic apply(input string tag, input logic [3:0] rq, input logic [3:0] a,
                         input logic [3:0] cl, input logic [3:0] eg, input logic ev,
                         input logic [1:0] ech, input logic ex, input logic ey);
        req  = rq;
        a_in = a;
        clr  = cl;
        #1;
        check({tag, " gnt"}, 8'(gnt), 8'(eg));
        @(posedge clk);
        #1;
        check({tag, " out_valid"}, 8'(out_valid), 8'(ev));
        if (ev) check({tag, " out_ch"}, 8'(out_ch), 8'(ech));
        check({tag, " out_x"}, 8'(out_x), 8'(ex));
        check({tag, " out_y"}, 8'(out_y), 8'(ey));
`ifdef RUN_LEN_EN
        if (ev) begin
            check({tag, " run_len>=2 vs x"}, 8'(run_len >= 2), 8'(out_x));
            check({tag, " run_len>=3 vs y"}, 8'(run_len >= 3), 8'(out_y));
        end
`endif
        req  = '0;
        clr  = '0;
        @(negedge clk);
    endtask

    initial begin
        // Channel 0 alone: 0,0,0,1,1,1.
        add(1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 2'd0, 0, 0);
        add(0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 2'd0, 1, 0);
        add(0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 2'd0, 1, 1);
        add(0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 2'd0, 0, 0);
        add(0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 2'd0, 1, 0);
        add(0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 2'd0, 1, 1);
        // All requesting from reset: rotation 0,1,2,3,0,1,2,3; second visit sees a repeat.
        add(1, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1, 2'd0, 0, 0);
        add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 1, 2'd1, 0, 0);
        add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 1, 2'd2, 0, 0);
        add(0, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 1, 2'd3, 0, 0);
        add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1, 2'd0, 1, 0);
        add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 1, 2'd1, 1, 0);
        add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 1, 2'd2, 1, 0);
        add(0, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 1, 2'd3, 1, 0);
        // Interleave ch1 (ones) and ch2 (zeros), then an idle cycle keeps rr_ptr at 3.
        add(1, 4'b0110, 4'b0010, 4'b0000, 4'b0010, 1, 2'd1, 0, 0);
        add(0, 4'b0110, 4'b0010, 4'b0000, 4'b0100, 1, 2'd2, 0, 0);
        add(0, 4'b0110, 4'b0010, 4'b0000, 4'b0010, 1, 2'd1, 1, 0);
        add(0, 4'b0110, 4'b0010, 4'b0000, 4'b0100, 1, 2'd2, 1, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 0, 0);
        add(0, 4'b1111, 4'b1111, 4'b0000, 4'b1000, 1, 2'd3, 0, 0);
        // Channel 3 filled with 1s, then clr with accept, then clr on another channel.
        add(1, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 1, 2'd3, 0, 0);
        add(0, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 1, 2'd3, 1, 0);
        add(0, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 1, 2'd3, 1, 1);
        add(0, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 1, 2'd3, 0, 0);
        add(0, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 1, 2'd3, 1, 0);
        add(0, 4'b1000, 4'b1000, 4'b0001, 4'b1000, 1, 2'd3, 1, 1);

        reset = 1'b1;
        req   = '0;
        a_in  = '0;
        clr   = '0;
        do_reset();

        // Reset state.
        check("reset out_valid", 8'(out_valid), 8'd0);
        check("reset out_x", 8'(out_x), 8'd0);
        check("reset out_y", 8'(out_y), 8'd0);
        check("reset out_ch", 8'(out_ch), 8'd0);
        check("reset gnt idle", 8'(gnt), 8'd0);
        req = 4'b1111;
        #1;
        check("reset rr_ptr gnt", 8'(gnt), 8'b0001);
        req = '0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_before) do_reset();
            apply($sformatf("vec%0d", i), vecs[i].req, vecs[i].a, vecs[i].clr, vecs[i].exp_gnt,
                  vecs[i].exp_valid, vecs[i].exp_ch, vecs[i].exp_x, vecs[i].exp_y);
        end

        // Reset in the cycle after a grant drops the result and wipes the context.
        do_reset();
        apply("rst_mid first", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 2'd0, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid out_valid", 8'(out_valid), 8'd0);
        @(negedge clk);
        reset = 1'b0;
        apply("rst_mid after", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 2'd0, 0, 0);

        // Reset coinciding with an accept: no result emerges.
        apply("pre_rst", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 2'd0, 1, 0);
        reset = 1'b1;
        req   = 4'b0001;
        a_in  = 4'b0001;
        @(posedge clk);
        #1;
        check("rst_accept out_valid", 8'(out_valid), 8'd0);
        @(negedge clk);
        reset = 1'b0;
        req   = '0;
        apply("rst_accept after", 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1, 2'd1, 0, 0);

`ifdef RUN_LEN_EN
        // Seven 1s on ch0 with RUN_W = 2 saturate at 3.
        begin
            logic [RUN_W-1:0] exp_run [7] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
            do_reset();
            check("reset run_len", 8'(run_len), 8'd0);
            for (int i = 0; i < 7; i++) begin
                apply($sformatf("run%0d", i), 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 2'd0,
                      i >= 1, i >= 2);
                check($sformatf("run%0d run_len", i), 8'(run_len), 8'(exp_run[i]));
            end
            @(negedge clk);
            check("run_len hold", 8'(run_len), 8'd3);
            apply("run clr", 4'b0001, 4'b0001, 4'b0001, 4'b0001, 1, 2'd0, 0, 0);
            check("run clr run_len", 8'(run_len), 8'd1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/history_stream_arbiter.md
Name: history_stream_arbiter

Overview:
- Shares one two/three-deep history pattern detector among NUM_CH independent 1-bit sample streams.
- Round-robin arbiter grants at most one requester per cycle.
- Each channel keeps its own saved history context (fill state plus last two samples), so interleaved streams never contaminate each other.
- Produces registered per-sample flags: x = current sample equals the previous one; y = current sample equals the previous two. Sits between the sample sources and the downstream event logic.

Parameters:
- NUM_CH, 4, number of requesting streams (2..16).
- RUN_W, 8, width of the run-length counter (used only with the optional feature).
- CH_W (derived localparam), $clog2(NUM_CH), channel index width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  NUM_CH  per-channel sample request; held high with a_in stable until granted
- a_in  in  NUM_CH  per-channel sample bit
- clr  in  NUM_CH  per-channel history flush, single-cycle pulse
- gnt  out  NUM_CH  one-hot grant, combinational from req and the RR pointer
- out_valid  out  1  result valid, one-cycle pulse
- out_ch  out  CH_W  channel of the result
- out_x  out  1  current sample equals the previous sample of that channel
- out_y  out  1  current sample equals the previous two samples of that channel
- run_len  out  RUN_W  current run length (only with RUN_LEN_EN)

Behaviour:
- Reset:
  - All channel contexts go to H_EMPTY with last bits 0.
  - rr_ptr = 0.
  - out_valid, out_x, out_y, out_ch = 0; run_len = 0.
- Arbitration:
  - gnt is the first asserted req starting at index rr_ptr, wrapping NUM_CH-1 -> 0. At most one bit is set.
  - gnt = 0 when no req is asserted.
  - A sample is accepted when req[i] & gnt[i].
  - After accepting channel k, rr_ptr <= (k+1) mod NUM_CH. rr_ptr is unchanged on idle cycles.
- Per-channel context FSM (h0 = last sample, h1 = sample before it):
  - H_EMPTY --accept--> H_ONE.
  - H_ONE --accept--> H_FULL.
  - H_FULL --accept--> H_FULL.
  - On every accept: h1 <= h0, h0 <= a.
- Flag computation for an accepted sample a, using the pre-update context:
  - x = (state != H_EMPTY) & (a == h0).
  - y = (state == H_FULL) & (a == h0) & (a == h1).
  - The flags apply to 0s and 1s symmetrically.
- Latency and output:
  - The result is registered; out_valid, out_ch, out_x and out_y appear on the cycle after acceptance.
  - out_valid is high for exactly one cycle per accepted sample.
  - Back-to-back accepts give back-to-back results.
  - out_x and out_y are 0 whenever out_valid = 0.
- clr[i]:
  - Returns channel i to H_EMPTY with h0 = h1 = 0. Other channels are unaffected.
  - clr[i] in the same cycle as an accept on channel i: the flush happens first, so the sample is treated as the first sample (x = y = 0) and the channel moves to H_ONE.
  - clr never affects rr_ptr or gnt.
- Reset asserted mid-operation: any in-flight result is dropped, so out_valid = 0 on the next cycle; every context and rr_ptr reinitialises.
- req deasserted before grant: the sample is discarded and there is no state change.

Optional Feature:
- Macro: RUN_LEN_EN.
- When defined:
  - Each channel keeps a RUN_W-bit counter of consecutive equal samples.
  - First sample, or a sample differing from h0: count = 1. Otherwise count + 1, saturating at 2^RUN_W - 1.
  - clr or reset sets the count to 0.
  - run_len carries the updated count of the accepted sample, registered alongside out_valid, and holds its value between results.
  - Consistency rule: out_x = (run_len >= 2) and out_y = (run_len >= 3).
- When not defined: no run_len port and no counters.

Test Plan:
- Channel 0 only, a = 0,0,0,1,1,1: x = 0,1,1,0,1,1 and y = 0,0,1,0,0,1, each one cycle after its grant.
- req = 4'b1111 held for 8 cycles from reset: gnt = 0001, 0010, 0100, 1000, 0001, ...; out_ch = 0,1,2,3,0, one cycle later.
- Interleave: ch1 gets 1,1 and ch2 gets 0,0, alternating grants (ch1, ch2, ch1, ch2): results x = 0,0,1,1 and y = 0 for all four. Proves context isolation.
- Channel 3 in H_FULL with history 1,1; clr[3] together with an accepted a = 1: x = 0, y = 0. The next a = 1 gives x = 1, y = 0.
- Reset pulsed in the cycle after a grant: out_valid = 0, and the next sample on that channel gives x = 0.
- RUN_LEN_EN with RUN_W = 2: seven consecutive 1s on ch0 give run_len = 1,2,3,3,3,3,3 (saturates).
